// File: rtl/uart_rx_ovs.sv
// Single-clock UART receiver: 2-flop input sync, internal oversample tick,
// mid-bit sampling with start-glitch rejection, parity/framing/overrun flags, valid/ready out.
module uart_rx_ovs #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 27,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rx_data_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SC_W-1:0]  SC_MID    = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BC_DLAST  = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0]  BC_SLAST  = BC_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rxs, rxs_d;
  logic [DIV_W-1:0]     div_cnt;
  logic [SC_W-1:0]      scnt;
  logic [BC_W-1:0]      bcnt;
  logic [DATA_BITS-1:0] sh;
  logic                 pe_acc, fe_acc, fe_now;
  logic                 tick;
  logic                 div_clr, scnt_clr, bcnt_clr, bcnt_inc;
  logic                 frm_init, shift_en, par_smp, stop_smp, done;

  // Sync stages reset to 1 so reset looks like an idle line, not a start edge.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx_data_in;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)          div_cnt <= '0;
    else if (div_clr) div_cnt <= '0;
    else if (tick)    div_cnt <= '0;
    else              div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    div_clr  = 1'b0;
    scnt_clr = 1'b0;
    bcnt_clr = 1'b0;
    bcnt_inc = 1'b0;
    frm_init = 1'b0;
    shift_en = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    done     = 1'b0;
    case (state_q)
      // Only a 1->0 transition starts a frame; a held-low line never retriggers.
      S_IDLE: begin
        if (rxs_d && !rxs) begin
          state_d  = S_START;
          div_clr  = 1'b1;
          scnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (tick && scnt == SC_MID) begin
          scnt_clr = 1'b1;
          bcnt_clr = 1'b1;
          frm_init = !rxs;
          state_d  = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && scnt == SC_LAST) begin
          scnt_clr = 1'b1;
          shift_en = 1'b1;
          bcnt_inc = 1'b1;
          if (bcnt == BC_DLAST) begin
            bcnt_clr = 1'b1;
            state_d  = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick && scnt == SC_LAST) begin
          scnt_clr = 1'b1;
          bcnt_clr = 1'b1;
          par_smp  = 1'b1;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (tick && scnt == SC_LAST) begin
          scnt_clr = 1'b1;
          stop_smp = 1'b1;
          bcnt_inc = 1'b1;
          if (bcnt == BC_SLAST) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      bcnt <= '0;
    end else begin
      if (scnt_clr)                        scnt <= '0;
      else if (tick && state_q != S_IDLE)  scnt <= scnt + 1'b1;
      if (bcnt_clr)                        bcnt <= '0;
      else if (bcnt_inc)                   bcnt <= bcnt + 1'b1;
    end
  end

  // LSB arrives first, so shifting in from the top leaves it at bit 0.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sh     <= '0;
      pe_acc <= 1'b0;
      fe_acc <= 1'b0;
    end else begin
      if (shift_en) sh <= {rxs, sh[DATA_BITS-1:1]};
      if (frm_init) begin
        pe_acc <= 1'b0;
        fe_acc <= 1'b0;
      end else begin
        if (par_smp)  pe_acc <= rxs ^ (^sh) ^ 1'(PARITY_ODD);
        if (stop_smp) fe_acc <= fe_acc | ~rxs;
      end
    end
  end

  // The completing stop sample is folded in the same cycle it is taken.
  assign fe_now = fe_acc | ~rxs;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_dout     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_dout    <= sh;
        parity_err <= pe_acc & (PARITY_EN != 0);
        frame_err  <= fe_now;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: four instances (8N1, 8E1, 8O1, 8N2) driven by a serial
// frame generator; received words are checked against a frame-level model.
module tb_uart_rx_ovs;

  localparam int OVS = 16;
  localparam int DIV = 4;
  localparam int BIT = OVS * DIV;
  localparam int NI  = 4;

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx    [NI];
  logic       rdy   [NI];
  logic [7:0] dout  [NI];
  logic       valid [NI];
  logic       pe    [NI];
  logic       fe    [NI];
  logic       ovr   [NI];
  logic       busy  [NI];

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_rx_ovs #(
      .DATA_BITS (8),
      .OVERSAMPLE(OVS),
      .CLK_DIV   (DIV),
      .PARITY_EN ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD((g == 2) ? 1 : 0),
      .STOP_BITS ((g == 3) ? 2 : 1)
    ) u_dut (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .rx_data_in (rx[g]),
      .rx_ready   (rdy[g]),
      .rx_dout    (dout[g]),
      .rx_valid   (valid[g]),
      .parity_err (pe[g]),
      .frame_err  (fe[g]),
      .overrun_err(ovr[g]),
      .rx_busy    (busy[g])
    );
  end

  // Frame-level view of each instance's configuration.
  function automatic bit par_en(input int i);  return (i == 1 || i == 2); endfunction
  function automatic bit par_odd(input int i); return (i == 2);           endfunction
  function automatic int stop_n(input int i);  return (i == 3) ? 2 : 1;   endfunction

  function automatic word_t model(input int i, input logic [7:0] d, input logic pb,
                                  input logic [1:0] st);
    word_t w;
    int    ones;
    ones = $countones(d) + int'(pb);
    w.idx = i;
    w.d   = d;
    w.pe  = par_en(i) && ((ones % 2) != int'(par_odd(i)));
    w.fe  = (st[0] == 1'b0) || (stop_n(i) == 2 && st[1] == 1'b0);
    return w;
  endfunction

  int    cyc = 0;
  int    t0 = 0;
  int    n_vec = 0;
  int    n_err = 0;
  word_t got_q [$];
  logic  vld_d    [NI] = '{default: 1'b0};
  int    ovr_cnt  [NI] = '{default: 0};
  int    rise_cyc [NI] = '{default: 0};

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Each rising rx_valid is one presented word.
  always @(negedge sys_clk) begin
    for (int i = 0; i < NI; i++) begin
      vld_d[i] <= valid[i];
      if (valid[i] && !vld_d[i]) begin
        got_q.push_back('{i, dout[i], pe[i], fe[i]});
        rise_cyc[i] <= cyc;
      end
      if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_wait();
    repeat (BIT) @(negedge sys_clk);
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic pb, input logic [1:0] st);
    t0 = cyc;
    rx[i] = 1'b0;
    bit_wait();
    for (int b = 0; b < 8; b++) begin
      rx[i] = d[b];
      bit_wait();
    end
    if (par_en(i)) begin
      rx[i] = pb;
      bit_wait();
    end
    rx[i] = st[0];
    bit_wait();
    if (stop_n(i) == 2) begin
      rx[i] = st[1];
      bit_wait();
    end
    rx[i] = 1'b1;
  endtask

  task automatic expect_word(input string tag, input word_t w);
    word_t g;
    chk({tag, "_cnt"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      chk({tag, "_idx"}, g.idx, w.idx);
      chk({tag, "_data"}, g.d, w.d);
      chk({tag, "_pe"}, g.pe, w.pe);
      chk({tag, "_fe"}, g.fe, w.fe);
    end
    got_q.delete();
  endtask

  task automatic chk_zero(input string tag, input int i);
    chk({tag, "_dout"}, dout[i], 0);
    chk({tag, "_valid"}, valid[i], 0);
    chk({tag, "_pe"}, pe[i], 0);
    chk({tag, "_fe"}, fe[i], 0);
    chk({tag, "_ovr"}, ovr[i], 0);
    chk({tag, "_busy"}, busy[i], 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       pb;
    logic [1:0] st;
    int         o0;

    for (int i = 0; i < NI; i++) begin
      rx[i]  = 1'b1;
      rdy[i] = 1'b1;
    end
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < NI; i++) chk_zero($sformatf("rst%0d", i), i);
    rst = 1'b0;
    repeat (10) @(negedge sys_clk);

    // 8N1 0xA5; 2 sync flops + 1 detect edge + (8 + 16*9) ticks * 4 cycles
    send(0, 8'hA5, 1'b0, 2'b11);
    bit_wait();
    chk("t1_lat", rise_cyc[0] - t0, 3 + DIV * (OVS / 2 + OVS * 9));
    expect_word("t1", model(0, 8'hA5, 1'b0, 2'b11));

    // 20-cycle glitch: aborted at mid start bit
    rx[0] = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("t2_busy_hi", busy[0], 1);
    repeat (10) @(negedge sys_clk);
    rx[0] = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("t2_busy_lo", busy[0], 0);
    repeat (2 * BIT) @(negedge sys_clk);
    chk("t2_none", got_q.size(), 0);
    send(0, 8'h5A, 1'b0, 2'b11);
    bit_wait();
    expect_word("t2", model(0, 8'h5A, 1'b0, 2'b11));

    // parity, even (1) then odd (2)
    for (int i = 1; i <= 2; i++) begin
      for (int p = 1; p >= 0; p--) begin
        send(i, 8'h3C, 1'(p), 2'b11);
        bit_wait();
        expect_word($sformatf("t3_i%0d_p%0d", i, p), model(i, 8'h3C, 1'(p), 2'b11));
      end
    end
    send(1, 8'h3C, 1'b1, 2'b11);
    bit_wait();
    chk("t3_even_pe1", pe[1], 1);
    got_q.delete();

    // two stop bits, second low; then a 30-bit break yields one 0x00 word
    send(3, 8'h81, 1'b0, 2'b01);
    bit_wait();
    expect_word("t4_fe", model(3, 8'h81, 1'b0, 2'b01));
    rx[3] = 1'b0;
    repeat (30 * BIT) @(negedge sys_clk);
    rx[3] = 1'b1;
    repeat (2 * BIT) @(negedge sys_clk);
    expect_word("t4_brk", model(3, 8'h00, 1'b0, 2'b00));
    send(3, 8'h11, 1'b0, 2'b11);
    bit_wait();
    expect_word("t4_after", model(3, 8'h11, 1'b0, 2'b11));

    // overrun with consumer stalled
    rdy[0] = 1'b0;
    send(0, 8'h12, 1'b0, 2'b11);
    bit_wait();
    o0 = ovr_cnt[0];
    send(0, 8'h34, 1'b0, 2'b11);
    bit_wait();
    chk("t5_ovr", ovr_cnt[0] - o0, 1);
    chk("t5_hold", dout[0], 8'h12);
    chk("t5_valid", valid[0], 1);
    expect_word("t5", model(0, 8'h12, 1'b0, 2'b11));
    rdy[0] = 1'b1;
    @(negedge sys_clk);
    rdy[0] = 1'b0;
    @(negedge sys_clk);
    chk("t5_drop", valid[0], 0);
    chk("t5_keep", dout[0], 8'h12);
    rdy[0] = 1'b1;

    // reset in the middle of the data bits
    fork
      send(0, 8'hFF, 1'b0, 2'b11);
      begin
        repeat (4 * BIT + 10) @(negedge sys_clk);
        rst = 1'b1;
        #1;
        chk_zero("t6_rst", 0);
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
      end
    join
    bit_wait();
    chk("t6_none", got_q.size(), 0);
    send(0, 8'h0F, 1'b0, 2'b11);
    bit_wait();
    expect_word("t6", model(0, 8'h0F, 1'b0, 2'b11));

    // random frames on every configuration
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 6; k++) begin
        d  = 8'($urandom);
        pb = 1'($urandom);
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        send(i, d, pb, st);
        repeat ($urandom_range(BIT, 3 * BIT)) @(negedge sys_clk);
        expect_word($sformatf("rnd_i%0d_k%0d", i, k), model(i, d, pb, st));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
